// File: rtl/sb1287_line_sensor_adc.sv
// sb1287_line_sensor_adc
//
// Scans three line sensors (left, centre, right) on an ADC128S022-style
// 8-channel 12-bit SPI ADC, round-robin. It publishes the readings as an
// atomically updated triplet with a one-cycle sample_valid strobe.
//
// The ADC answers each frame with the conversion of the channel that was
// addressed in the previous frame. The first frame after leaving IDLE is
// therefore a dummy "priming" frame whose result is thrown away.
//
// Optional feature: define SB1287_ADC_AVG_EN to average 4 consecutive
// triplets. Each commit then carries (sum of 4 readings) >> 2, and
// sample_valid fires once per 4 triplets.
//
// Parameters:
//   CLK_DIV    clk cycles per SCLK half-period (>= 1)
//   LEFT_CH    ADC channel of the left sensor
//   CENTRE_CH  ADC channel of the centre sensor
//   RIGHT_CH   ADC channel of the right sensor
//
// Ports:
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   enable         scan while high; a running frame always completes
//   adc_dout       ADC serial data out
//   adc_cs_n       ADC chip select (active low)
//   adc_sclk       ADC serial clock (idles high)
//   adc_din        ADC serial data in (control word, MSB first)
//   left, centre, right  last committed readings
//   sample_valid   one-cycle pulse on each commit

module sb1287_line_sensor_adc #(
  parameter int         CLK_DIV   = 8,
  parameter logic [2:0] LEFT_CH   = 3'd3,
  parameter logic [2:0] CENTRE_CH = 3'd4,
  parameter logic [2:0] RIGHT_CH  = 3'd5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        adc_dout,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic        adc_din,
  output logic [11:0] left,
  output logic [11:0] centre,
  output logic [11:0] right,
  output logic        sample_valid
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;
  // Channel addressed by the frame currently being run.
  typedef enum logic [1:0] {SEQ_LEFT, SEQ_CENTRE, SEQ_RIGHT} seq_t;

  state_t           state, state_next;
  seq_t             seq;
  logic             primed;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_idx;
  logic [11:0]      shift_in;   // only the last 12 captured bits are kept
  logic [2:0]       cur_ch;
  logic [15:0]      ctrl_word;

  logic cnt_done, last_bit;
  logic frame_start, begin_shift, sclk_rise, sclk_fall, frame_end, stop;

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    cnt_done    = (cnt == CNT_LAST);
    last_bit    = (bit_idx == 4'd15);
    begin_shift = 1'b0;
    sclk_rise   = 1'b0;
    sclk_fall   = 1'b0;
    frame_end   = 1'b0;
    stop        = 1'b0;
    case (state)
      IDLE: begin
        if (enable) state_next = SETUP;
      end
      SETUP: begin
        if (cnt_done) begin
          state_next  = SHIFT;
          begin_shift = 1'b1;
        end
      end
      SHIFT: begin
        if (cnt_done) begin
          if (!adc_sclk) begin
            sclk_rise = 1'b1;
          end else if (last_bit) begin
            frame_end  = 1'b1;
            state_next = GAP;
          end else begin
            sclk_fall = 1'b1;
          end
        end
      end
      GAP: begin
        if (cnt_done) begin
          if (enable) begin
            state_next = SETUP;
          end else begin
            state_next = IDLE;
            stop       = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    frame_start = (state_next == SETUP) && (state != SETUP);
  end

  always_comb begin
    cur_ch = LEFT_CH;
    case (seq)
      SEQ_CENTRE: cur_ch = CENTRE_CH;
      SEQ_RIGHT:  cur_ch = RIGHT_CH;
      default:    cur_ch = LEFT_CH;
    endcase
    ctrl_word = {2'b00, cur_ch, 11'd0};
  end

  // ---------------------------------------------------------------------
  // SPI serialiser / deserialiser
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      bit_idx  <= '0;
      shift_in <= '0;
      adc_cs_n <= 1'b1;
      adc_sclk <= 1'b1;
      adc_din  <= 1'b0;
    end else begin
      // The counter restarts on every state change and every SCLK half-period.
      if (state == IDLE || state_next != state || (state == SHIFT && cnt_done))
        cnt <= '0;
      else
        cnt <= cnt + CNT_W'(1);

      if (frame_start) adc_cs_n <= 1'b0;
      if (frame_end)   adc_cs_n <= 1'b1;

      if (begin_shift) begin
        adc_sclk <= 1'b0;
        adc_din  <= ctrl_word[15];
        bit_idx  <= '0;
      end
      if (sclk_rise) begin
        adc_sclk <= 1'b1;
        shift_in <= {shift_in[10:0], adc_dout};
      end
      if (sclk_fall) begin
        adc_sclk <= 1'b0;
        adc_din  <= ctrl_word[4'd14 - bit_idx];
        bit_idx  <= bit_idx + 4'd1;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Sequencing and commit. When primed, a frame returns the sensor that
  // precedes the one it addresses: CENTRE frame -> left, RIGHT -> centre,
  // LEFT -> right (which completes the triplet).
  // ---------------------------------------------------------------------
`ifdef SB1287_ADC_AVG_EN
  logic [13:0] acc_left, acc_centre, acc_right, sum_right;
  logic [1:0]  trip_cnt;

  assign sum_right = acc_right + {2'b00, shift_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq          <= SEQ_LEFT;
      primed       <= 1'b0;
      acc_left     <= '0;
      acc_centre   <= '0;
      acc_right    <= '0;
      trip_cnt     <= '0;
      left         <= '0;
      centre       <= '0;
      right        <= '0;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (frame_end) begin
        if (!primed) begin
          primed <= 1'b1;
          seq    <= SEQ_CENTRE;
        end else begin
          case (seq)
            SEQ_CENTRE: begin
              acc_left <= acc_left + {2'b00, shift_in};
              seq      <= SEQ_RIGHT;
            end
            SEQ_RIGHT: begin
              acc_centre <= acc_centre + {2'b00, shift_in};
              seq        <= SEQ_LEFT;
            end
            default: begin
              seq <= SEQ_CENTRE;
              if (trip_cnt == 2'd3) begin
                left         <= acc_left[13:2];
                centre       <= acc_centre[13:2];
                right        <= sum_right[13:2];
                sample_valid <= 1'b1;
                acc_left     <= '0;
                acc_centre   <= '0;
                acc_right    <= '0;
                trip_cnt     <= '0;
              end else begin
                acc_right <= sum_right;
                trip_cnt  <= trip_cnt + 2'd1;
              end
            end
          endcase
        end
      end else if (stop) begin
        seq        <= SEQ_LEFT;
        primed     <= 1'b0;
        acc_left   <= '0;
        acc_centre <= '0;
        acc_right  <= '0;
        trip_cnt   <= '0;
      end
    end
  end
`else
  logic [11:0] shadow_left, shadow_centre;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq           <= SEQ_LEFT;
      primed        <= 1'b0;
      shadow_left   <= '0;
      shadow_centre <= '0;
      left          <= '0;
      centre        <= '0;
      right         <= '0;
      sample_valid  <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      if (frame_end) begin
        if (!primed) begin
          primed <= 1'b1;
          seq    <= SEQ_CENTRE;
        end else begin
          case (seq)
            SEQ_CENTRE: begin
              shadow_left <= shift_in;
              seq         <= SEQ_RIGHT;
            end
            SEQ_RIGHT: begin
              shadow_centre <= shift_in;
              seq           <= SEQ_LEFT;
            end
            default: begin
              left         <= shadow_left;
              centre       <= shadow_centre;
              right        <= shift_in;
              sample_valid <= 1'b1;
              seq          <= SEQ_CENTRE;
            end
          endcase
        end
      end else if (stop) begin
        seq    <= SEQ_LEFT;
        primed <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sb1287_line_sensor_adc.sv
// Testbench for sb1287_line_sensor_adc (CLK_DIV = 2).
// A behavioural ADC model answers each frame with the channel addressed in
// the previous frame and decodes the control word. Stimulus pushes expected
// commits (cycle + values) into a queue; a monitor pops and compares them
// whenever sample_valid is seen, and otherwise checks that outputs hold.
// With SB1287_ADC_AVG_EN defined, the run checks averaging instead.

module tb_sb1287_line_sensor_adc;
  localparam int DIV = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        adc_dout = 1'b0;
  logic        adc_cs_n, adc_sclk, adc_din, sample_valid;
  logic [11:0] left, centre, right;

  sb1287_line_sensor_adc #(.CLK_DIV(DIV), .LEFT_CH(3'd3), .CENTRE_CH(3'd4), .RIGHT_CH(3'd5)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .adc_dout(adc_dout),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_din(adc_din),
    .left(left), .centre(centre), .right(right), .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [11:0] l, c, r;
  } exp_t;
  exp_t expq[$];

  // ---------------- ADC model ----------------
  logic [11:0] val [8];
  logic [3:0]  lead = 4'h0;
  logic [2:0]  prev_addr = 3'd0;
  logic [15:0] resp, rx;
  int          nbits = 0;
  int          frame_no = 0;
  logic [2:0]  chans [3] = '{3'd3, 3'd4, 3'd5};
`ifdef SB1287_ADC_AVG_EN
  logic [11:0] avg_tab [4] = '{12'd100, 12'd101, 12'd102, 12'd105};
  int          left_reads = 0;
`endif

  always @(negedge adc_cs_n) begin
    resp = {lead, val[prev_addr]};
`ifdef SB1287_ADC_AVG_EN
    if (prev_addr == 3'd3) begin
      resp = {lead, avg_tab[left_reads % 4]};
      left_reads++;
    end
`endif
    nbits = 0;
    rx = '0;
    adc_dout = resp[15];
  end

  always @(posedge adc_sclk) begin
    if (rst_n && !adc_cs_n && nbits < 16) begin
      rx = {rx[14:0], adc_din};
      nbits++;
      adc_dout = (nbits < 16) ? resp[15 - nbits] : 1'b0;
    end
  end

  always @(posedge adc_cs_n) begin
    if (rst_n && nbits == 16) begin
      checks++;
      if (rx[15:14] != 2'b00 || rx[10:0] != 11'd0) begin
        errors++;
        $display("FAIL ctrl_zero_bits frame %0d: got word %h, required bits 15:14 and 10:0 zero", frame_no, rx);
      end
      checks++;
      if (rx[13:11] != chans[frame_no % 3]) begin
        errors++;
        $display("FAIL ctrl_addr frame %0d: got %0d, required %0d", frame_no, rx[13:11], chans[frame_no % 3]);
      end
      $display("frame %0d: control word %h addr %0d", frame_no, rx, rx[13:11]);
      frame_no++;
      prev_addr = rx[13:11];
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [11:0] snap_l = '0, snap_c = '0, snap_r = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      snap_l = '0; snap_c = '0; snap_r = '0;
    end else if (sample_valid) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid at cycle %0d: got %h/%h/%h, required no commit", cyc, left, centre, right);
      end else begin
        exp_t e;
        e = expq.pop_front();
        if (cyc != e.cyc || left != e.l || centre != e.c || right != e.r) begin
          errors++;
          $display("FAIL commit: got cycle %0d %h/%h/%h, required cycle %0d %h/%h/%h",
                   cyc, left, centre, right, e.cyc, e.l, e.c, e.r);
        end else begin
          $display("commit at cycle %0d: left=%h centre=%h right=%h", cyc, left, centre, right);
        end
      end
      snap_l = left; snap_c = centre; snap_r = right;
    end else begin
      checks++;
      if (left != snap_l || centre != snap_c || right != snap_r) begin
        errors++;
        $display("FAIL atomic_hold at cycle %0d: got %h/%h/%h, required %h/%h/%h",
                 cyc, left, centre, right, snap_l, snap_c, snap_r);
        snap_l = left; snap_c = centre; snap_r = right;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [11:0] act, input logic [11:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end else begin
      $display("check %s: %h", name, act);
    end
  endtask

  task automatic push(input int c, input logic [11:0] l, input logic [11:0] ce, input logic [11:0] r);
    exp_t e;
    e.cyc = c; e.l = l; e.c = ce; e.r = r;
    expq.push_back(e);
  endtask

  task automatic wait_drain(input int budget);
    int k = 0;
    while (expq.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (expq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL commit_timeout: got %0d commits outstanding, required 0", expq.size());
      expq.delete();
    end
  endtask

  // Returns the cyc value after cycle 0 (the edge sampling enable high).
  task automatic start_run(output int base);
    frame_no = 0;
    @(negedge clk);
    enable = 1'b1;
    base = cyc + 1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_cs_n"}, 12'(adc_cs_n), 12'd1);
    check({tag, "_sclk"}, 12'(adc_sclk), 12'd1);
    check({tag, "_din"}, 12'(adc_din), 12'd0);
    check({tag, "_left"}, left, 12'h000);
    check({tag, "_centre"}, centre, 12'h000);
    check({tag, "_right"}, right, 12'h000);
    check({tag, "_valid"}, 12'(sample_valid), 12'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    for (int i = 0; i < 8; i++) val[i] = 12'hEEE;
    val[0] = 12'hBAD;
    val[3] = 12'h123;
    val[4] = 12'h456;
    val[5] = 12'h789;

    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_cs_n", 12'(adc_cs_n), 12'd1);

`ifdef SB1287_ADC_AVG_EN
    // Left readings 100,101,102,105 over 4 triplets -> 102; one commit only.
    start_run(base);
    push(base + 882, 12'd102, 12'h456, 12'h789);
    wait_drain(1000);
    enable = 1'b0;
    repeat (200) @(negedge clk);
    check("avg_hold_left", left, 12'd102);
`else
    // Basic capture: commits at cycle 270 and 474.
    start_run(base);
    push(base + 270, 12'h123, 12'h456, 12'h789);
    push(base + 474, 12'h123, 12'h456, 12'h789);
    wait_drain(600);

    // Enable dropped during frame 8 (second position of the third triplet).
    wait_until(base + 560);
    enable = 1'b0;
    wait_until(base + 700);
    check("drop_cs_n", 12'(adc_cs_n), 12'd1);
    check("drop_left", left, 12'h123);
    check("drop_centre", centre, 12'h456);
    check("drop_right", right, 12'h789);

    // Full scale and leading junk; restart must re-prime (commit at +270).
    val[3] = 12'hFFF;
    val[4] = 12'h000;
    val[5] = 12'hA5A;
    lead = 4'hA;
    start_run(base);
    push(base + 270, 12'hFFF, 12'h000, 12'hA5A);
    wait_drain(400);

    // Reset while SCLK is low in the SHIFT phase of frame 4.
    wait_until(base + 311);
    #2;
    rst_n = 1'b0;
    enable = 1'b0;
    #1;
    check_reset_state("midreset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check("post_reset_left", left, 12'h000);
    check("post_reset_cs_n", 12'(adc_cs_n), 12'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
